// File: rtl/axil_reg_if_rd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_reg_if_rd : AXI4-lite read slave to register-bus read strobe bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
module axil_reg_if_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_INIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic w_ar_hs;
  logic w_timeout_hit;
  logic w_unused;

  assign w_ar_hs       = s_axil_arvalid && arready_q;
  assign w_timeout_hit = (TIMEOUT != 0) && (timer_q == '0);
  assign w_unused      = ^s_axil_arprot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_ar_hs) state_d = S_ACCESS;
      S_ACCESS: if (reg_rd_ack || (!reg_rd_wait && w_timeout_hit)) state_d = S_RESP;
      S_RESP:   if (rvalid_q && s_axil_rready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state.
  always_comb begin
    arready_d = (state_d == S_IDLE);
    rvalid_d  = (state_d == S_RESP);
    rd_en_d   = (state_d == S_ACCESS);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_addr_d = rd_addr_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE: begin
        if (w_ar_hs) begin
          rd_addr_d = s_axil_araddr;
          timer_d   = TIMER_INIT;
        end
      end
      S_ACCESS: begin
        if (reg_rd_ack) begin
          rdata_d = reg_rd_data;
          rresp_d = RESP_OKAY;
        end else if (reg_rd_wait) begin
          timer_d = timer_q;
        end else if (w_timeout_hit) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: ;
    endcase
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_rd_en      = rd_en_q;
  assign reg_rd_addr    = rd_addr_q;

endmodule
`default_nettype wire
